// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU result stage: op codes, occupancy encoding
// and the flag bundle stored alongside each buffered result.
package alu32_pkg;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_NOT = 3'd3;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_SRL = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_NOP = 3'd7;

   // State code equals the occupancy reported on Count.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   typedef struct packed {
      logic       co;
      logic       zero;
      logic       neg;
      logic [2:0] op;
   } flag_t;

endpackage

// File: rtl/alu32_res_entry.sv
// One buffered ALU result plus its flags; loads when i_en is high and
// clears to zero on reset.
module alu32_res_entry
   import alu32_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_result,
   input  flag_t            i_flags,
   output logic [WIDTH-1:0] o_result,
   output flag_t            o_flags
);

   logic [WIDTH-1:0] r_result;
   flag_t            r_flags;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_result <= '0;
         r_flags  <= '0;
      end else if (i_en) begin
         r_result <= i_result;
         r_flags  <= i_flags;
      end
   end

   assign o_result = r_result;
   assign o_flags  = r_flags;

endmodule

// File: rtl/alu32_result_stage.sv
// Two-entry in-order buffer for ALU results with zero/neg/carry flag capture
// and a saturating counter of discarded NOP results.
//
// state    | meaning
// ST_EMPTY | no entries, OutValid low
// ST_ONE   | head valid, tail free
// ST_FULL  | head and tail valid, InReady low
module alu32_result_stage
   import alu32_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DROPW = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InResult,
   input  logic             InCO,
   input  logic [2:0]       InOp,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutResult,
   output logic             OutCO,
   output logic             OutZero,
   output logic             OutNeg,
   output logic [2:0]       OutOp,
   output logic [1:0]       Count,
   output logic [DROPW-1:0] DropCnt
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [DROPW-1:0] r_drop;
   logic             w_push, w_push_st, w_push_nop, w_pop;
   logic             w_head_en, w_tail_en, w_head_from_tail;
   flag_t            w_in_flags, w_head_flags, w_tail_flags, w_head_d_flags;
   logic [WIDTH-1:0] w_head_result, w_tail_result, w_head_d_result;

   assign InReady    = (r_state != ST_FULL);
   assign OutValid   = (r_state != ST_EMPTY);
   assign w_push     = InValid & InReady;
   assign w_push_nop = w_push & (InOp == OP_NOP);
   assign w_push_st  = w_push & (InOp != OP_NOP);
   assign w_pop      = OutValid & OutReady;

   // Carry is only meaningful for adds; other ops report CO=0.
   assign w_in_flags.co   = InCO & (InOp == OP_ADD);
   assign w_in_flags.zero = (InResult == '0);
   assign w_in_flags.neg  = InResult[WIDTH-1];
   assign w_in_flags.op   = InOp;

   always_comb begin
      w_state_nxt      = r_state;
      w_head_en        = 1'b0;
      w_tail_en        = 1'b0;
      w_head_from_tail = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_push_st) begin
               w_head_en   = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            case ({w_push_st, w_pop})
               2'b10: begin
                  w_tail_en   = 1'b1;
                  w_state_nxt = ST_FULL;
               end
               2'b01:   w_state_nxt = ST_EMPTY;
               2'b11:   w_head_en   = 1'b1;
               default: w_state_nxt = ST_ONE;
            endcase
         end
         ST_FULL: begin
            if (w_pop) begin
               w_head_en        = 1'b1;
               w_head_from_tail = 1'b1;
               w_state_nxt      = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   assign w_head_d_result = w_head_from_tail ? w_tail_result : InResult;
   assign w_head_d_flags  = w_head_from_tail ? w_tail_flags  : w_in_flags;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= ST_EMPTY;
         r_drop  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push_nop && (r_drop != {DROPW{1'b1}}))
            r_drop <= r_drop + 1'b1;
      end
   end

   alu32_res_entry #(.WIDTH(WIDTH)) u_head (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .i_en     (w_head_en),
      .i_result (w_head_d_result),
      .i_flags  (w_head_d_flags),
      .o_result (w_head_result),
      .o_flags  (w_head_flags)
   );

   alu32_res_entry #(.WIDTH(WIDTH)) u_tail (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .i_en     (w_tail_en),
      .i_result (InResult),
      .i_flags  (w_in_flags),
      .o_result (w_tail_result),
      .o_flags  (w_tail_flags)
   );

   assign OutResult = w_head_result;
   assign OutCO     = w_head_flags.co;
   assign OutZero   = w_head_flags.zero;
   assign OutNeg    = w_head_flags.neg;
   assign OutOp     = w_head_flags.op;
   assign Count     = r_state;
   assign DropCnt   = r_drop;

endmodule

// File: tb/tb_alu32_result_stage.sv
// Scoreboard bench for alu32_result_stage: the driver queues hand-computed
// expected entries on each accepted push, the monitor checks every pop.
module tb_alu32_result_stage;

   logic        Clk;
   logic        Rst_n;
   logic        InValid;
   logic        InReady;
   logic [31:0] InResult;
   logic        InCO;
   logic [2:0]  InOp;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutResult;
   logic        OutCO;
   logic        OutZero;
   logic        OutNeg;
   logic [2:0]  OutOp;
   logic [1:0]  Count;
   logic [7:0]  DropCnt;

   alu32_result_stage #(.WIDTH(32), .DROPW(8)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .InValid   (InValid),
      .InReady   (InReady),
      .InResult  (InResult),
      .InCO      (InCO),
      .InOp      (InOp),
      .OutValid  (OutValid),
      .OutReady  (OutReady),
      .OutResult (OutResult),
      .OutCO     (OutCO),
      .OutZero   (OutZero),
      .OutNeg    (OutNeg),
      .OutOp     (OutOp),
      .Count     (Count),
      .DropCnt   (DropCnt)
   );

   typedef struct packed {
      logic [31:0] res;
      logic        co;
      logic        z;
      logic        n;
      logic [2:0]  op;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_pass  = 0;
   int   n_total = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Holds InValid until the handshake happens; expected flags are supplied by the caller.
   task automatic send(input logic [31:0] res, input logic co, input logic [2:0] op,
                       input logic eco, input logic ez, input logic en);
      bit done = 1'b0;
      InValid  = 1'b1;
      InResult = res;
      InCO     = co;
      InOp     = op;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge Clk);
         if (InReady) begin
            if (op != 3'd7) sb.push_back({res, eco, ez, en, op});
            done = 1'b1;
         end
         @(posedge Clk);
         #1;
      end
      InValid = 1'b0;
      InOp    = 3'd0;
      if (!done) begin
         n_total++;
         $display("FAIL send_timeout: value %0h never accepted", res);
      end
   endtask

   task automatic drain();
      bit done = 1'b0;
      OutReady = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge Clk);
         if (Count == 2'd0 && sb.size() == 0) done = 1'b1;
      end
      chk("drain_count", {62'd0, Count}, 64'd0);
      chk("drain_sb_left", sb.size(), 64'd0);
      @(posedge Clk);
      #1;
   endtask

   // Monitor: every handshake at the output must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge Clk);
         if (Rst_n && OutValid && OutReady) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_out: got result %0h with nothing expected", OutResult);
            end else begin
               m_e = sb.pop_front();
               chk("out_result", {32'd0, OutResult}, {32'd0, m_e.res});
               chk("out_co",     {63'd0, OutCO},     {63'd0, m_e.co});
               chk("out_zero",   {63'd0, OutZero},   {63'd0, m_e.z});
               chk("out_neg",    {63'd0, OutNeg},    {63'd0, m_e.n});
               chk("out_op",     {61'd0, OutOp},     {61'd0, m_e.op});
            end
         end
      end
   end

   initial begin
      Rst_n    = 1'b0;
      InValid  = 1'b0;
      InResult = '0;
      InCO     = 1'b0;
      InOp     = 3'd0;
      OutReady = 1'b0;
      #8;
      chk("rst_count",    {62'd0, Count},     64'd0);
      chk("rst_outvalid", {63'd0, OutValid},  64'd0);
      chk("rst_result",   {32'd0, OutResult}, 64'd0);
      chk("rst_flags",    {58'd0, OutCO, OutZero, OutNeg, OutOp}, 64'd0);
      chk("rst_dropcnt",  {56'd0, DropCnt},   64'd0);
      Rst_n = 1'b1;
      #0;
      chk("rst_inready",  {63'd0, InReady},   64'd1);

      // S1: add with carry and MSB set, accepted on the first edge after reset
      send(32'hFFFF_FFFF, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
      chk("s1_outvalid", {63'd0, OutValid}, 64'd1);
      chk("s1_co",       {63'd0, OutCO},    64'd1);
      chk("s1_neg",      {63'd0, OutNeg},   64'd1);
      chk("s1_zero",     {63'd0, OutZero},  64'd0);
      chk("s1_count",    {62'd0, Count},    64'd1);
      drain();

      // S2: zero result from AND, carry masked
      OutReady = 1'b0;
      send(32'h0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
      chk("s2_zero", {63'd0, OutZero}, 64'd1);
      chk("s2_co",   {63'd0, OutCO},   64'd0);
      drain();

      // S3: fill, hold off a third push, then release in order
      OutReady = 1'b0;
      send(32'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      send(32'd6, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
      chk("s3_count_full", {62'd0, Count},   64'd2);
      chk("s3_inready",    {63'd0, InReady}, 64'd0);
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge Clk);
               chk("s3_hold_inready", {63'd0, InReady}, 64'd0);
               chk("s3_hold_head",    {32'd0, OutResult}, 64'd5);
            end
            @(posedge Clk);
            #1;
            OutReady = 1'b1;
         end
         send(32'd7, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      join
      drain();

      // S4: push while popping in ONE keeps Count and loads the new head directly
      OutReady = 1'b0;
      send(32'hA, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
      OutReady = 1'b1;
      send(32'hB, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
      chk("s4_count", {62'd0, Count},     64'd1);
      chk("s4_head",  {32'd0, OutResult}, 64'hB);
      drain();

      // S5: NOPs are consumed, never stored, counter saturates
      for (int k = 0; k < 100; k++) send(32'h1234, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
      chk("s5_drop100", {56'd0, DropCnt}, 64'd100);
      for (int k = 0; k < 200; k++) send(32'h1234, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
      chk("s5_count",    {62'd0, Count},    64'd0);
      chk("s5_outvalid", {63'd0, OutValid}, 64'd0);
      chk("s5_dropsat",  {56'd0, DropCnt},  64'd255);

      // S6: reset mid-operation with two buffered entries
      OutReady = 1'b0;
      send(32'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
      send(32'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
      chk("s6_full", {62'd0, Count}, 64'd2);
      #2;
      Rst_n = 1'b0;
      sb.delete();
      #1;
      chk("s6_count",    {62'd0, Count},     64'd0);
      chk("s6_outvalid", {63'd0, OutValid},  64'd0);
      chk("s6_result",   {32'd0, OutResult}, 64'd0);
      chk("s6_dropcnt",  {56'd0, DropCnt},   64'd0);
      #2;
      Rst_n    = 1'b1;
      OutReady = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         chk("s6_no_old", {63'd0, OutValid}, 64'd0);
      end
      @(posedge Clk);
      #1;
      send(32'h8000_0000, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
